comm_master: RTL and testbench

COMM_MASTER -- requirements
Module: comm_master

---
 rtl/comm_master.sv | 89 ++++++++
 tb/tb_comm_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/comm_master.sv
// comm_master: sends a captured 16-bit command as two 8N1 UART frames, high byte first,
// and flags completion on cmd_cmplt until the next accepted request.
module comm_master #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        TX,
    output logic        cmd_cmplt
);
    localparam int BW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW} state_t;

    state_t        state, state_n;
    logic [15:0]   hold, hold_n;
    logic [9:0]    shift, shift_n;
    logic [BW-1:0] baud, baud_n;
    logic [3:0]    bit_cnt, bit_n;
    logic          tx_n, cmplt_n, fin, fin_n, bit_end, last;

    assign bit_end = baud == BW'(BAUD_DIV - 1);
    assign last    = bit_end && bit_cnt == 4'd9;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            shift     <= '0;
            baud      <= '0;
            bit_cnt   <= '0;
            fin       <= 1'b0;
            TX        <= 1'b1;
            cmd_cmplt <= 1'b0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            shift     <= shift_n;
            baud      <= baud_n;
            bit_cnt   <= bit_n;
            fin       <= fin_n;
            TX        <= tx_n;
            cmd_cmplt <= cmplt_n;
        end
    end

    // TX follows shift[0] one clock late, so the last stop-bit edge lands in IDLE and
    // fin carries completion into the following cycle, where a waiting request can preempt it.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        shift_n = shift;
        baud_n  = baud;
        bit_n   = bit_cnt;
        cmplt_n = cmd_cmplt;
        tx_n    = state == IDLE ? 1'b1 : shift[0];
        fin_n   = state == SEND_LOW && last;
        if (state == IDLE) begin
            if (snd_cmd) begin
                state_n = SEND_HIGH;
                hold_n  = cmd;
                shift_n = {1'b1, cmd[15:8], 1'b0};
                baud_n  = '0;
                bit_n   = '0;
                cmplt_n = 1'b0;
            end else if (fin) begin
                cmplt_n = 1'b1;
            end
        end else begin
            baud_n = bit_end ? '0 : baud + 1'b1;
            if (bit_end) begin
                shift_n = {1'b1, shift[9:1]};
                bit_n   = bit_cnt + 4'd1;
            end
            if (last) begin
                bit_n = '0;
                if (state == SEND_HIGH) begin
                    state_n = SEND_LOW;
                    hold_n  = {hold[7:0], hold[15:8]};
                    shift_n = {1'b1, hold[7:0], 1'b0};
                end else begin
                    state_n = IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_comm_master.sv
// tb_comm_master: directed checks of frame timing, back-to-back requests, reset abort
// and default-rate bit/command lengths.
module tb_comm_master;
    localparam int B = 16;
    localparam int C = 20 * B + 1;

    logic        clk = 1'b0, rst_n = 1'b0, snd_cmd = 1'b0, snd_d = 1'b0;
    logic [15:0] cmd = '0, cmd_d = '0;
    logic        tx, cmplt, tx_d, cmplt_d;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .TX(tx), .cmd_cmplt(cmplt)
    );

    comm_master dut_d (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd_d), .cmd(cmd_d), .TX(tx_d), .cmd_cmplt(cmplt_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // expected TX k clocks after the accept edge for a single command w
    function automatic logic exp_tx(input logic [15:0] w, input int k);
        int j, b;
        logic [7:0] by;
        if (k < 1 || k > 20 * B) return 1'b1;
        j  = (k - 1) / B;
        b  = j % 10;
        by = j < 10 ? w[15:8] : w[7:0];
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : by[b-1];
    endfunction

    task automatic send(input logic [15:0] c);
        cmd     = c;
        snd_cmd = 1'b1;
        tick;
        snd_cmd = 1'b0;
    endtask

    task automatic trace_one(input string tag, input logic [15:0] w);
        for (int k = 0; k <= C; k++) begin
            if (k != 0) tick;
            check($sformatf("%s tx k=%0d", tag, k), tx, exp_tx(w, k));
            check($sformatf("%s cmplt k=%0d", tag, k), cmplt, k == C);
        end
    endtask

    task automatic rx(output logic [7:0] d, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        d  = '0;
        while (tx !== 1'b0 && n < 40 * B) begin
            tick;
            n++;
        end
        if (tx !== 1'b0) return;
        repeat (B / 2) tick;
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (B) tick;
            d[i] = tx;
        end
        repeat (B) tick;
        ok = tx;
    endtask

    initial begin
        logic [15:0] words [2];
        logic [7:0]  d;
        logic        ok;
        int          n, t;
        words[0] = 16'hFFFF;
        words[1] = 16'hAAAA;

        repeat (3) tick;
        check("reset tx", tx, 1'b1);
        check("reset cmplt", cmplt, 1'b0);
        check("reset tx_d", tx_d, 1'b1);
        check("reset cmplt_d", cmplt_d, 1'b0);
        rst_n = 1'b1;
        tick;
        check("idle cmplt", cmplt, 1'b0);

        send(16'h002D);
        trace_one("s1", 16'h002D);

        for (int w = 0; w < 2; w++) begin
            repeat (3) tick;
            check($sformatf("s2 between cmplt %0d", w), cmplt, 1'b1);
            send(words[w]);
            check($sformatf("s2 accept cmplt %0d", w), cmplt, 1'b0);
            for (int y = 0; y < 2; y++) begin
                rx(d, ok);
                check($sformatf("s2 stop %0d.%0d", w, y), ok, 1'b1);
                check($sformatf("s2 byte %0d.%0d", w, y), d, words[w][15 - 8 * y -: 8]);
            end
            check($sformatf("s2 during cmplt %0d", w), cmplt, 1'b0);
            repeat (B) tick;
            check($sformatf("s2 done cmplt %0d", w), cmplt, 1'b1);
            check($sformatf("s2 done tx %0d", w), tx, 1'b1);
        end

        cmd     = 16'h5555;
        snd_cmd = 1'b1;
        tick;
        for (int k = 0; k <= 2 * C; k++) begin
            if (k != 0) tick;
            if (k == 50) cmd = 16'h0000;
            if (k == 330) snd_cmd = 1'b0;
            check($sformatf("s3 tx k=%0d", k), tx,
                  k <= C ? exp_tx(16'h5555, k) : exp_tx(16'h0000, k - C));
            check($sformatf("s3 cmplt k=%0d", k), cmplt, k == 2 * C);
        end

        send(16'hC30F);
        repeat (249) tick;
        check("s4 pre-reset tx", tx, 1'b0);
        rst_n = 1'b0;
        tick;
        check("s4 reset tx", tx, 1'b1);
        check("s4 reset cmplt", cmplt, 1'b0);
        cmd     = 16'h9A3C;
        snd_cmd = 1'b1;
        tick;
        check("s4 held tx", tx, 1'b1);
        check("s4 held cmplt", cmplt, 1'b0);
        rst_n = 1'b1;
        tick;
        snd_cmd = 1'b0;
        trace_one("s4", 16'h9A3C);

        cmd_d = 16'h5555;
        snd_d = 1'b1;
        tick;
        snd_d = 1'b0;
        n = 0;
        while (tx_d && n < 10) begin
            tick;
            n++;
        end
        check("s5 start latency", n, 1);
        t = 0;
        while (!tx_d && t < 5000) begin
            tick;
            t++;
        end
        check("s5 bit length", t, 2604);
        while (!cmplt_d && t < 60000) begin
            tick;
            t++;
        end
        check("s5 command length", t, 52080);
        check("s5 idle tx", tx_d, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
